// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares single-port DMEM between CPU M-stage and aux port.
// DMEM_ARB_STARVE_EN enables the aux starvation counter / forced grant.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [DATA_W/8-1:0] cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic                aux_req,
  input  logic [DATA_W/8-1:0] aux_we,
  input  logic [ADDR_W-1:0]   aux_addr,
  input  logic [DATA_W-1:0]   aux_wdata,
  output logic                aux_gnt,
  output logic [DATA_W-1:0]   aux_rdata,
  output logic                aux_rvalid,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_CPU,
    SEL_AUX,
    SEL_FORCED
  } sel_t;

  sel_t              sel;
  logic              force_aux;
  logic              cpu_gnt;
  logic [1:0]        owner;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] aux_hold;

`ifdef DMEM_ARB_STARVE_EN
  logic [CW-1:0] starve_cnt;

  // Count consecutive denied aux cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!aux_req || aux_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Aux is pushed through once it has waited long enough
  always_comb begin
    force_aux = aux_req && (starve_cnt == CW'(STARVE_MAX));
  end
`else
  // Strict CPU priority: aux only gets idle CPU cycles
  always_comb begin
    force_aux = 1'b0;
  end
`endif

  // Per-cycle grant selection and memory port mux
  always_comb begin
    sel       = SEL_IDLE;
    cpu_gnt   = 1'b0;
    aux_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_din   = '0;
    if (cpu_req && !force_aux) begin
      sel = SEL_CPU;
    end else if (force_aux) begin
      sel = SEL_FORCED;
    end else if (aux_req) begin
      sel = SEL_AUX;
    end
    unique case (sel)
      SEL_CPU: begin
        cpu_gnt  = 1'b1;
        mem_en   = 1'b1;
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
      end
      SEL_AUX, SEL_FORCED: begin
        aux_gnt  = 1'b1;
        mem_en   = 1'b1;
        mem_we   = aux_we;
        mem_addr = aux_addr;
        mem_din  = aux_wdata;
      end
      default: ;
    endcase
    cpu_stall = cpu_req && !cpu_gnt;
  end

  // Tag which requester owns the read returning next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= 2'b00;
    end else begin
      owner <= {aux_gnt && (aux_we == BE_W'(0)),
                cpu_gnt && (cpu_we == BE_W'(0))};
    end
  end

  // Hold the last returned word for each requester
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold <= '0;
      aux_hold <= '0;
    end else begin
      if (cpu_rvalid) cpu_hold <= mem_dout;
      if (aux_rvalid) aux_hold <= mem_dout;
    end
  end

  // Read return: reset kills any in-flight read
  always_comb begin
    cpu_rvalid = owner[0] && !rst;
    aux_rvalid = owner[1] && !rst;
    cpu_rdata  = cpu_rvalid ? mem_dout : cpu_hold;
    aux_rdata  = aux_rvalid ? mem_dout : aux_hold;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of dmem_port_arbiter
// with a write-first BRAM model behind the memory port.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        aux_req;
  logic [3:0]  aux_we;
  logic [11:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic [31:0] aux_rdata;
  logic        aux_rvalid;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:4095];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
    .aux_rvalid(aux_rvalid),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Write-first single-port BRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      logic [31:0] w;
      w = mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) w[b*8 +: 8] = mem_din[b*8 +: 8];
      mem[mem_addr] <= w;
      mem_dout <= w;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h030] = 32'hCAFEF00D;
    mem_dout = 32'h0;
    idle();
    rst = 1;
    // reset, with a read issued in the reset cycle
    cpu_req = 1; cpu_addr = 12'h010;
    step();
    mid();
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("rst_aux_rvalid", {31'b0, aux_rvalid}, 0);
    chk("rst_comb_en", {31'b0, mem_en}, 1);
    step();
    rst = 0;
    idle();
    mid();
    chk("post_rst_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("post_rst_rdata", cpu_rdata, 0);
    chk("post_rst_aux_rdata", aux_rdata, 0);

    // 1: cpu read
    cpu_req = 1; cpu_addr = 12'h010;
    mid();
    chk("t1_en", {31'b0, mem_en}, 1);
    chk("t1_addr", {20'b0, mem_addr}, 32'h010);
    chk("t1_stall", {31'b0, cpu_stall}, 0);
    step();
    idle();
    mid();
    chk("t1_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_stall2", {31'b0, cpu_stall}, 0);
    step();
    mid();
    chk("t1_rvalid_off", {31'b0, cpu_rvalid}, 0);
    chk("t1_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // 2: partial write then back-to-back read
    cpu_req = 1; cpu_we = 4'b0011;
    cpu_addr = 12'h020; cpu_wdata = 32'h1234ABCD;
    mid();
    chk("t2_we", {28'b0, mem_we}, 32'h3);
    chk("t2_din", mem_din, 32'h1234ABCD);
    step();
    cpu_we = 0; cpu_wdata = 0;
    mid();
    chk("t2_wr_rvalid", {31'b0, cpu_rvalid}, 0);
    step();
    idle();
    mid();
    chk("t2_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("t2_rdata", cpu_rdata, 32'h0000ABCD);
    step();
    mid();
    chk("t2_one_pulse", {31'b0, cpu_rvalid}, 0);

    // 4: aux read with idle CPU
    aux_req = 1; aux_addr = 12'h030;
    mid();
    chk("t4_gnt", {31'b0, aux_gnt}, 1);
    chk("t4_addr", {20'b0, mem_addr}, 32'h030);
    step();
    idle();
    mid();
    chk("t4_aux_rvalid", {31'b0, aux_rvalid}, 1);
    chk("t4_aux_rdata", aux_rdata, 32'hCAFEF00D);
    chk("t4_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    step();

    // 3 / 6: both requesting continuously
    cpu_req = 1; cpu_addr = 12'h010;
    aux_req = 1; aux_addr = 12'h030;
`ifdef DMEM_ARB_STARVE_EN
    for (int c = 1; c <= 10; c++) begin
      mid();
      chk($sformatf("t3_gnt_c%0d", c), {31'b0, aux_gnt},
          (c % 5 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_stall_c%0d", c), {31'b0, cpu_stall},
          (c % 5 == 0) ? 32'd1 : 32'd0);
      step();
    end
`else
    for (int c = 1; c <= 20; c++) begin
      mid();
      chk($sformatf("t6_gnt_c%0d", c), {31'b0, aux_gnt}, 0);
      chk($sformatf("t6_stall_c%0d", c), {31'b0, cpu_stall}, 0);
      step();
    end
    cpu_req = 0;
    mid();
    chk("t6_gnt_drop", {31'b0, aux_gnt}, 1);
    chk("t6_addr_drop", {20'b0, mem_addr}, 32'h030);
    step();
    aux_req = 0;
    mid();
    chk("t6_aux_rvalid", {31'b0, aux_rvalid}, 1);
    step();
`endif
    idle();
    step();

    // 5: reset in the cycle after a cpu read issue
    cpu_req = 1; cpu_addr = 12'h010;
    step();
    idle();
    rst = 1;
    mid();
    chk("t5_rvalid_rst", {31'b0, cpu_rvalid}, 0);
    step();
    rst = 0;
    mid();
    chk("t5_rvalid_after", {31'b0, cpu_rvalid}, 0);
    chk("t5_rdata_cleared", cpu_rdata, 0);
    step();
    mid();
    chk("t5_rvalid_later", {31'b0, cpu_rvalid}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
